vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16; H_SYNC, default 96; H_BACK, default 48; these are horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameter V_DISPLAY, default 480; V_FRONT, default 10; V_SYNC, default 2; V_BACK, default 33; these are in lines.
REQ-004 SHALL have parameter SYNC_ACTIVE, default 0, meaning the asserted sync level (0 = active-low).
REQ-005 SHALL have parameter ANIM_MAX, default 200, meaning the triangle-oscillator upper bound.
REQ-006 clk  input  1  pixel clock, 25.175 MHz nominal.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 en  input  1  pixel advance enable; when low, all state holds.
REQ-009 hsync  output  1  horizontal sync, level per SYNC_ACTIVE.
REQ-010 vsync  output  1  vertical sync, level per SYNC_ACTIVE.
REQ-011 display_on  output  1  high while hpos < H_DISPLAY and vpos < V_DISPLAY.
REQ-012 hpos  output  10  current pixel column.
REQ-013 vpos  output  10  current line.
REQ-014 line_start  output  1  one-clock strobe while hpos==0.
REQ-015 frame_start  output  1  one-clock strobe while hpos==0 and vpos==0.
REQ-016 frame_count  output  8  frames completed, modulo 256.
REQ-017 anim  output  8  triangle value, updated once per frame.

Function
REQ-018 H_TOTAL SHALL equal H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL SHALL equal V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
REQ-019 On each clk edge with en=1, hpos SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vpos SHALL increment in the same edge.
REQ-020 vpos SHALL wrap from V_TOTAL-1 to 0 on the edge where hpos also wraps.
REQ-021 All outputs SHALL be registered, decoded from next-state counters, so every output is aligned to the same hpos/vpos with zero cycles of skew.
REQ-022 hsync SHALL be asserted for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (656..751); deasserted otherwise.
REQ-023 vsync SHALL be asserted for vpos in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (490..491) for all hpos on those lines.
REQ-024 frame_count SHALL increment on the edge where hpos and vpos both wrap to 0; 255 SHALL wrap to 0.
REQ-025 anim SHALL update on that same edge: if direction=up, it increments; if direction=down, it decrements.
REQ-026 Direction SHALL become down on the edge anim becomes ANIM_MAX, and up on the edge anim becomes 0; anim SHALL never exceed ANIM_MAX or underflow.
REQ-027 With en=0, counters, outputs, frame_count, anim and direction SHALL all hold; strobes SHALL retain their value.
REQ-028 ANIM_MAX SHALL be legal in 1..255; widths SHALL be sized so H_TOTAL-1 and V_TOTAL-1 fit in 10 bits.

Reset
REQ-029 While rst_n=0, the block SHALL drive hpos=0, vpos=0, display_on=1, line_start=1, frame_start=1, frame_count=0, anim=0, direction=up, and both syncs deasserted (=~SYNC_ACTIVE).
REQ-030 Reset assertion mid-line or mid-frame SHALL take effect immediately, without clk.
REQ-031 Release SHALL be synchronised internally (2-flop) so the first count occurs on the second clk edge after rst_n rises.

Structure
REQ-032 A shared package SHALL hold the 640x480@60 timing constants, and the 10-bit position width, for reuse by pattern stages.
REQ-033 The triangle oscillator SHALL be one sub-module, tri_osc (ports: clk, rst_n, step, value), so pattern stages can instantiate further oscillators.

Verification
REQ-034 Reset, release, en=1 -> hpos counts 0..799; on the edge hpos becomes 656, hsync goes 0 for exactly 96 clocks; display_on=0 from hpos 640.
REQ-035 Run 420000 clocks -> vsync=0 exactly on lines 490-491 (1600 clocks); frame_start pulses once; frame_count=1; anim=1.
REQ-036 Run 201 frames -> anim reaches 200 after 200 frames, then 199; run 400 frames -> anim=0, then 1 on frame 401.
REQ-037 Toggle en=0 for 37 clocks mid-line at hpos=300 -> all outputs frozen; hpos resumes at 301.
REQ-038 Assert rst_n=0 at hpos=700, vpos=100, frame_count=5 -> same-cycle outputs match REQ-029 with no clk edge.
REQ-039 SYNC_ACTIVE=1 build -> hsync and vsync polarity inverted; timing identical to REQ-034 and REQ-035.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 raster constants and position types for the VGA timing
// generator and any downstream pattern stages.
package vga_timing_gen_pkg;

   localparam int POS_W  = 10;
   localparam int ANIM_W = 8;

   localparam int VGA_H_DISPLAY = 640;
   localparam int VGA_H_FRONT   = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BACK    = 48;
   localparam int VGA_V_DISPLAY = 480;
   localparam int VGA_V_FRONT   = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BACK    = 33;
   localparam int VGA_ANIM_MAX  = 200;

   typedef logic [POS_W-1:0]  pos_t;
   typedef logic [ANIM_W-1:0] anim_t;

   function automatic logic in_window(pos_t pos, pos_t lo, pos_t hi);
      return (pos >= lo) && (pos <= hi);
   endfunction

endpackage

// File: rtl/vga_timing_gen_tri_osc.sv
// Up/down triangle oscillator: one step per strobe, bouncing between 0 and MAX.
module tri_osc
   import vga_timing_gen_pkg::*;
#(
   parameter int MAX = VGA_ANIM_MAX
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        step,
   output logic [ANIM_W-1:0] value
);

   localparam anim_t MAX_V = anim_t'(MAX);

   anim_t r_value;
   logic  r_up;
   anim_t w_nxt;

   assign w_nxt = r_up ? r_value + anim_t'(1) : r_value - anim_t'(1);
   assign value = r_value;

   // Direction flips on the edge that lands on an end point, so the value
   // never leaves 0..MAX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_value <= '0;
         r_up    <= 1'b1;
      end else if (step) begin
         r_value <= w_nxt;
         if (w_nxt == MAX_V)
            r_up <= 1'b0;
         else if (w_nxt == '0)
            r_up <= 1'b1;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync,
// blanking and strobe outputs, frame counter and a per-frame triangle value.
module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int H_DISPLAY   = VGA_H_DISPLAY,
   parameter int H_FRONT     = VGA_H_FRONT,
   parameter int H_SYNC      = VGA_H_SYNC,
   parameter int H_BACK      = VGA_H_BACK,
   parameter int V_DISPLAY   = VGA_V_DISPLAY,
   parameter int V_FRONT     = VGA_V_FRONT,
   parameter int V_SYNC      = VGA_V_SYNC,
   parameter int V_BACK      = VGA_V_BACK,
   parameter bit SYNC_ACTIVE = 1'b0,
   parameter int ANIM_MAX    = VGA_ANIM_MAX
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic              hsync,
   output logic              vsync,
   output logic              display_on,
   output logic [POS_W-1:0]  hpos,
   output logic [POS_W-1:0]  vpos,
   output logic              line_start,
   output logic              frame_start,
   output logic [ANIM_W-1:0] frame_count,
   output logic [ANIM_W-1:0] anim
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam pos_t H_LAST = pos_t'(H_TOTAL - 1);
   localparam pos_t V_LAST = pos_t'(V_TOTAL - 1);
   localparam pos_t H_DISP = pos_t'(H_DISPLAY);
   localparam pos_t V_DISP = pos_t'(V_DISPLAY);
   localparam pos_t HS_LO  = pos_t'(H_DISPLAY + H_FRONT);
   localparam pos_t HS_HI  = pos_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam pos_t VS_LO  = pos_t'(V_DISPLAY + V_FRONT);
   localparam pos_t VS_HI  = pos_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   if (H_TOTAL > (1 << POS_W) || V_TOTAL > (1 << POS_W)) begin : g_bad_total
      $error("vga_timing_gen: raster totals do not fit the position width");
   end
   if (ANIM_MAX < 1 || ANIM_MAX > 255) begin : g_bad_anim
      $error("vga_timing_gen: ANIM_MAX must be within 1..255");
   end

   logic [1:0] r_rst_sync;
   pos_t       r_hpos;
   pos_t       r_vpos;
   logic       r_hsync;
   logic       r_vsync;
   logic       r_display_on;
   logic       r_line_start;
   logic       r_frame_start;
   anim_t      r_frame_count;

   logic       w_adv;
   logic       w_h_last;
   logic       w_v_last;
   logic       w_frame_wrap;
   pos_t       w_h_nxt;
   pos_t       w_v_nxt;
   anim_t      w_anim;

   // Release is resynchronised; counting starts on the second edge after rst_n rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_rst_sync <= '0;
      else
         r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_adv        = en & r_rst_sync[0];
   assign w_h_last     = (r_hpos == H_LAST);
   assign w_v_last     = (r_vpos == V_LAST);
   assign w_frame_wrap = w_h_last & w_v_last;
   assign w_h_nxt      = w_h_last ? '0 : r_hpos + pos_t'(1);

   always_comb begin
      w_v_nxt = r_vpos;
      if (w_h_last)
         w_v_nxt = w_v_last ? '0 : r_vpos + pos_t'(1);
   end

   // Every output is decoded from the next position so all of them line up
   // with hpos/vpos on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hpos        <= '0;
         r_vpos        <= '0;
         r_hsync       <= ~SYNC_ACTIVE;
         r_vsync       <= ~SYNC_ACTIVE;
         r_display_on  <= 1'b1;
         r_line_start  <= 1'b1;
         r_frame_start <= 1'b1;
         r_frame_count <= '0;
      end else if (w_adv) begin
         r_hpos        <= w_h_nxt;
         r_vpos        <= w_v_nxt;
         r_hsync       <= in_window(w_h_nxt, HS_LO, HS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         r_vsync       <= in_window(w_v_nxt, VS_LO, VS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         r_display_on  <= (w_h_nxt < H_DISP) && (w_v_nxt < V_DISP);
         r_line_start  <= (w_h_nxt == '0);
         r_frame_start <= (w_h_nxt == '0) && (w_v_nxt == '0);
         if (w_frame_wrap)
            r_frame_count <= r_frame_count + anim_t'(1);
      end
   end

   // The oscillator sits behind the synchronised reset; it only steps on a
   // frame wrap, so its one-cycle-later release is never observable.
   tri_osc #(
      .MAX (ANIM_MAX)
   ) u_tri_osc (
      .clk   (clk),
      .rst_n (r_rst_sync[1]),
      .step  (w_adv & w_frame_wrap),
      .value (w_anim)
   );

   assign hpos        = r_hpos;
   assign vpos        = r_vpos;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign display_on  = r_display_on;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign frame_count = r_frame_count;
   assign anim        = w_anim;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a shrunken raster (both sync polarities) plus the
// default 640x480 build, checked every cycle against a position-count model.
module tb_vga_timing_gen;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       de;
      logic       ls;
      logic       fs;
      logic [9:0] h;
      logic [9:0] v;
      logic [7:0] fc;
      logic [7:0] anim;
   } outs_t;

   typedef struct packed {
      outs_t s;
      outs_t i;
      outs_t d;
   } exp_t;

   typedef struct {
      logic  en;
      int    n;
      int    h;
      int    v;
      int    fc;
      int    anim;
      logic  hs;
      logic  vs;
      string name;
   } vec_t;

   logic clk;
   logic rst_n;
   logic en;

   logic       s_hs, s_vs, s_de, s_ls, s_fs;
   logic [9:0] s_h, s_v;
   logic [7:0] s_fc, s_anim;
   logic       i_hs, i_vs, i_de, i_ls, i_fs;
   logic [9:0] i_h, i_v;
   logic [7:0] i_fc, i_anim;
   logic       d_hs, d_vs, d_de, d_ls, d_fs;
   logic [9:0] d_h, d_v;
   logic [7:0] d_fc, d_anim;

   outs_t act_s, act_i, act_d;
   assign act_s = {s_hs, s_vs, s_de, s_ls, s_fs, s_h, s_v, s_fc, s_anim};
   assign act_i = {i_hs, i_vs, i_de, i_ls, i_fs, i_h, i_v, i_fc, i_anim};
   assign act_d = {d_hs, d_vs, d_de, d_ls, d_fs, d_h, d_v, d_fc, d_anim};

   int   n_checks = 0;
   int   n_err    = 0;
   int   m_t      = 0;
   int   rel_edges = 0;
   exp_t sb_q[$];
   vec_t vecs[10];

   vga_timing_gen #(
      .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .SYNC_ACTIVE(1'b0), .ANIM_MAX(3)
   ) u_small (
      .clk(clk), .rst_n(rst_n), .en(en),
      .hsync(s_hs), .vsync(s_vs), .display_on(s_de), .hpos(s_h), .vpos(s_v),
      .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc), .anim(s_anim)
   );

   vga_timing_gen #(
      .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .SYNC_ACTIVE(1'b1), .ANIM_MAX(3)
   ) u_inv (
      .clk(clk), .rst_n(rst_n), .en(en),
      .hsync(i_hs), .vsync(i_vs), .display_on(i_de), .hpos(i_h), .vpos(i_v),
      .line_start(i_ls), .frame_start(i_fs), .frame_count(i_fc), .anim(i_anim)
   );

   vga_timing_gen u_def (
      .clk(clk), .rst_n(rst_n), .en(en),
      .hsync(d_hs), .vsync(d_vs), .display_on(d_de), .hpos(d_h), .vpos(d_v),
      .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc), .anim(d_anim)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs after t counting edges, from plain division of t.
   function automatic outs_t model(int t, int hd, int hf, int hs, int hb,
                                   int vd, int vf, int vs, int vb, int amax, bit act);
      outs_t o;
      int ht = hd + hf + hs + hb;
      int vt = vd + vf + vs + vb;
      int fr = t / (ht * vt);
      int h  = t % ht;
      int v  = (t / ht) % vt;
      int p  = fr % (2 * amax);
      o.h    = 10'(h);
      o.v    = 10'(v);
      o.de   = (h < hd) && (v < vd);
      o.ls   = (h == 0);
      o.fs   = (h == 0) && (v == 0);
      o.hs   = (h >= hd + hf && h < hd + hf + hs) ? act : !act;
      o.vs   = (v >= vd + vf && v < vd + vf + vs) ? act : !act;
      o.fc   = 8'(fr % 256);
      o.anim = 8'((p <= amax) ? p : 2 * amax - p);
      return o;
   endfunction

   function automatic exp_t expect_at(int t);
      exp_t e;
      e.s = model(t, 10, 2, 3, 2, 6, 1, 2, 1, 3, 1'b0);
      e.i = model(t, 10, 2, 3, 2, 6, 1, 2, 1, 3, 1'b1);
      e.d = model(t, 640, 16, 96, 48, 480, 10, 2, 33, 200, 1'b0);
      return e;
   endfunction

   task automatic cmp_outs(input string name, input outs_t got, input outs_t exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s t=%0d got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d anim=%0d exp h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d anim=%0d",
                  name, m_t, got.h, got.v, got.hs, got.vs, got.de, got.ls, got.fs, got.fc, got.anim,
                  exp.h, exp.v, exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.fc, exp.anim);
      end
   endtask

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // Drive en, predict the next edge, then compare just after it.
   task automatic step(input logic en_v);
      exp_t e;
      en = en_v;
      if (rst_n) begin
         if (en_v && rel_edges >= 1)
            m_t++;
         rel_edges++;
      end
      sb_q.push_back(expect_at(m_t));
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      cmp_outs("small", act_s, e.s);
      cmp_outs("inv", act_i, e.i);
      cmp_outs("default", act_d, e.d);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_hpos"}, int'(s_h), 0);
      chk({tag, "_vpos"}, int'(s_v), 0);
      chk({tag, "_de"}, int'(s_de), 1);
      chk({tag, "_ls"}, int'(s_ls), 1);
      chk({tag, "_fs"}, int'(s_fs), 1);
      chk({tag, "_fc"}, int'(s_fc), 0);
      chk({tag, "_anim"}, int'(s_anim), 0);
      chk({tag, "_hs"}, int'(s_hs), 1);
      chk({tag, "_vs"}, int'(s_vs), 1);
      chk({tag, "_inv_hs"}, int'(i_hs), 0);
      chk({tag, "_inv_vs"}, int'(i_vs), 0);
      chk({tag, "_def_hpos"}, int'(d_h), 0);
   endtask

   initial begin
      vecs[0] = '{1'b1, 1,   0, 0, 0, 0, 1'b1, 1'b1, "release_edge1"};
      vecs[1] = '{1'b1, 12, 12, 0, 0, 0, 1'b0, 1'b1, "hsync_first"};
      vecs[2] = '{1'b0, 5,  12, 0, 0, 0, 1'b0, 1'b1, "en_low_hold"};
      vecs[3] = '{1'b1, 5,   0, 1, 0, 0, 1'b1, 1'b1, "line_wrap"};
      vecs[4] = '{1'b1, 153, 0, 0, 1, 1, 1'b1, 1'b1, "frame_wrap"};
      vecs[5] = '{1'b1, 340, 0, 0, 3, 3, 1'b1, 1'b1, "anim_peak"};
      vecs[6] = '{1'b1, 170, 0, 0, 4, 2, 1'b1, 1'b1, "anim_down"};
      vecs[7] = '{1'b1, 340, 0, 0, 6, 0, 1'b1, 1'b1, "anim_floor"};
      vecs[8] = '{1'b1, 170, 0, 0, 7, 1, 1'b1, 1'b1, "anim_up_again"};
      vecs[9] = '{1'b1, 125, 6, 7, 7, 1, 1'b1, 1'b0, "vsync_line"};

      rst_n = 1'b0;
      en    = 1'b1;
      repeat (3) step(1'b1);
      chk_reset_vals("rst");

      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         repeat (vecs[k].n) step(vecs[k].en);
         chk({vecs[k].name, "_hpos"}, int'(s_h), vecs[k].h);
         chk({vecs[k].name, "_vpos"}, int'(s_v), vecs[k].v);
         chk({vecs[k].name, "_fc"}, int'(s_fc), vecs[k].fc);
         chk({vecs[k].name, "_anim"}, int'(s_anim), vecs[k].anim);
         chk({vecs[k].name, "_hs"}, int'(s_hs), int'(vecs[k].hs));
         chk({vecs[k].name, "_vs"}, int'(s_vs), int'(vecs[k].vs));
         chk({vecs[k].name, "_inv_hs"}, int'(i_hs), int'(!vecs[k].hs));
      end

      // Mid-frame reset between edges must act without a clock.
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      m_t       = 0;
      rel_edges = 0;
      repeat (2) step(1'b1);

      rst_n = 1'b1;
      step(1'b1);
      chk("rerelease_edge1_hpos", int'(s_h), 0);
      step(1'b1);
      chk("rerelease_edge2_hpos", int'(s_h), 1);
      step(1'b1);
      chk("rerelease_edge3_hpos", int'(s_h), 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
